// File: rtl/envelope_follower.sv
// ----------------------------------------------------------------------------
// envelope_follower
//   Recovers an 8-bit amplitude envelope and a note-present gate from a
//   stream of signed audio samples. It mirrors the synth envelope generator:
//   attack and release smoothing are 4-bit right-shift amounts.
//
//   The pipeline has three stages:
//     1. magnitude   |sample|. The most negative code saturates to full scale.
//     2. envelope    env moves toward mag by (diff >> a|r). The step is never
//                    smaller than 1 and never overshoots mag.
//     3. outputs     amplitude is the top 8 bits of env. The gate FSM then
//                    advances on that new amplitude.
//   A sample_valid at cycle N produces out_valid at cycle N+3. The pipeline
//   accepts a new sample every cycle.
//
// Ports
//   clk           system clock
//   reset_n       synchronous active-low reset
//   sample_valid  one-cycle strobe qualifying sample
//   sample        signed two's-complement audio sample
//   a, r          attack / release smoothing shift (0 = instant)
//   open_th       amplitude at or above which the gate opens
//   close_th      amplitude below which the hold count runs
//   amplitude     envelope magnitude (top 8 bits)
//   gate          signal-present gate
//   out_valid     one-cycle strobe: amplitude/gate updated this cycle
// ----------------------------------------------------------------------------
module envelope_follower #(
    parameter int unsigned SAMPLE_BITS  = 16,
    parameter int unsigned HOLD_SAMPLES = 2400
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          sample_valid,
    input  logic signed [SAMPLE_BITS-1:0] sample,
    input  logic        [3:0]             a,
    input  logic        [3:0]             r,
    input  logic        [7:0]             open_th,
    input  logic        [7:0]             close_th,
    output logic        [7:0]             amplitude,
    output logic                          gate,
    output logic                          out_valid
);

    localparam int unsigned MAG_BITS = SAMPLE_BITS - 1;
    localparam int unsigned CNT_BITS = $clog2(HOLD_SAMPLES + 1);
    localparam logic [CNT_BITS-1:0] HOLD_LAST = CNT_BITS'(HOLD_SAMPLES);
    localparam logic [CNT_BITS-1:0] CNT_ONE   = CNT_BITS'(1);

    typedef enum logic [1:0] {
        CLOSED = 2'd0,
        OPEN   = 2'd1,
        HOLD   = 2'd2
    } gate_state_t;

    // ------------------------------------------------------------------
    // Pipeline registers
    // ------------------------------------------------------------------
    logic                  s1_valid;
    logic [MAG_BITS-1:0]   s1_mag;
    logic                  s2_valid;
    logic [MAG_BITS-1:0]   env;
    gate_state_t           state;
    logic [CNT_BITS-1:0]   hold_cnt;

    // ------------------------------------------------------------------
    // Stage 1 combinational: saturating absolute value
    // ------------------------------------------------------------------
    logic [SAMPLE_BITS-1:0] sample_u;
    logic [MAG_BITS-1:0]    neg_low_c;
    logic [MAG_BITS-1:0]    mag_c;

    assign sample_u = $unsigned(sample);

    // Two's-complement negation taken modulo 2^MAG_BITS. The only input
    // whose magnitude does not fit in MAG_BITS is the most negative code,
    // so that one case is clamped to full scale.
    assign neg_low_c = (~sample_u[MAG_BITS-1:0]) + MAG_BITS'(1);

    always_comb begin
        mag_c = sample_u[MAG_BITS-1:0];
        if (sample_u[SAMPLE_BITS-1]) begin
            if (sample_u[MAG_BITS-1:0] == '0) begin
                mag_c = '1;
            end else begin
                mag_c = neg_low_c;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2 combinational: envelope step toward the magnitude
    // ------------------------------------------------------------------
    logic                rising_c;
    logic [MAG_BITS-1:0] diff_c;
    logic [MAG_BITS-1:0] shifted_c;
    logic [MAG_BITS-1:0] step_c;
    logic [MAG_BITS-1:0] env_next_c;

    always_comb begin
        rising_c  = (s1_mag > env);
        diff_c    = rising_c ? (s1_mag - env) : (env - s1_mag);
        shifted_c = rising_c ? (diff_c >> a) : (diff_c >> r);
        // The minimum step of 1 lets env reach mag exactly. Because
        // step <= diff, env can never overshoot mag.
        step_c    = shifted_c;
        if ((shifted_c == '0) && (diff_c != '0)) begin
            step_c = MAG_BITS'(1);
        end
        env_next_c = rising_c ? (env + step_c) : (env - step_c);
    end

    // ------------------------------------------------------------------
    // Stage 3 combinational: amplitude seen by the gate FSM this update
    // ------------------------------------------------------------------
    logic [7:0] amp_c;
    logic [CNT_BITS-1:0] cnt_inc_c;

    assign amp_c     = env[MAG_BITS-1 -: 8];
    assign cnt_inc_c = hold_cnt + CNT_ONE;

    // ------------------------------------------------------------------
    // Stage 1 register: capture magnitude of the incoming sample
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_mag   <= '0;
        end else begin
            s1_valid <= sample_valid;
            if (sample_valid) begin
                s1_mag <= mag_c;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2 register: envelope state, advanced only by valid samples
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s2_valid <= 1'b0;
            env      <= '0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                env <= env_next_c;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 3 register: outputs and gate FSM with hysteresis and hold
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            amplitude <= 8'd0;
            gate      <= 1'b0;
            out_valid <= 1'b0;
            state     <= CLOSED;
            hold_cnt  <= '0;
        end else begin
            out_valid <= s2_valid;
            if (s2_valid) begin
                amplitude <= amp_c;
                case (state)
                    CLOSED: begin
                        if (amp_c >= open_th) begin
                            state <= OPEN;
                            gate  <= 1'b1;
                        end
                    end
                    OPEN: begin
                        if (amp_c < close_th) begin
                            // A one-sample hold expires on the first
                            // below-threshold update.
                            if (HOLD_LAST == CNT_ONE) begin
                                state    <= CLOSED;
                                gate     <= 1'b0;
                                hold_cnt <= '0;
                            end else begin
                                state    <= HOLD;
                                hold_cnt <= CNT_ONE;
                            end
                        end
                    end
                    HOLD: begin
                        // Re-arming takes priority over expiry.
                        if (amp_c >= close_th) begin
                            state    <= OPEN;
                            hold_cnt <= '0;
                        end else if (cnt_inc_c == HOLD_LAST) begin
                            state    <= CLOSED;
                            gate     <= 1'b0;
                            hold_cnt <= '0;
                        end else begin
                            hold_cnt <= cnt_inc_c;
                        end
                    end
                    default: begin
                        state    <= CLOSED;
                        gate     <= 1'b0;
                        hold_cnt <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_envelope_follower.sv
// ----------------------------------------------------------------------------
// tb_envelope_follower
//   Self-checking bench for envelope_follower. A behavioural model predicts
//   amplitude and gate for each driven sample and queues the prediction. The
//   monitor pops one prediction per out_valid pulse and compares it. Each
//   scenario task adds its own inline checks for latency, reset, the
//   hysteresis milestones and idle behaviour.
// ----------------------------------------------------------------------------
module tb_envelope_follower;

    localparam int unsigned SB   = 16;
    localparam int unsigned HOLD = 4;

    logic                 clk;
    logic                 reset_n;
    logic                 sample_valid;
    logic signed [SB-1:0] sample;
    logic [3:0]           a;
    logic [3:0]           r;
    logic [7:0]           open_th;
    logic [7:0]           close_th;
    logic [7:0]           amplitude;
    logic                 gate;
    logic                 out_valid;

    envelope_follower #(
        .SAMPLE_BITS  (SB),
        .HOLD_SAMPLES (HOLD)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .sample_valid (sample_valid),
        .sample       (sample),
        .a            (a),
        .r            (r),
        .open_th      (open_th),
        .close_th     (close_th),
        .amplitude    (amplitude),
        .gate         (gate),
        .out_valid    (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] amp;
        logic       gate;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model state
    int m_env   = 0;
    int m_state = 0;   // 0 CLOSED, 1 OPEN, 2 HOLD
    int m_cnt   = 0;

    function automatic logic [7:0] m_amp();
        return 8'(m_env >> 7);
    endfunction

    function automatic logic m_gate();
        return (m_state != 0);
    endfunction

    task automatic model_reset();
        m_env   = 0;
        m_state = 0;
        m_cnt   = 0;
    endtask

    // Advance the model by one sample and queue the predicted output.
    task automatic model_push(input logic [SB-1:0] s);
        int v;
        int mag;
        int diff;
        int step;
        int amp;
        exp_t e;
        v   = int'($signed(s));
        mag = (v < 0) ? -v : v;
        if (mag > 32767) mag = 32767;
        if (mag > m_env) begin
            diff = mag - m_env;
            step = diff >> a;
            if (step == 0) step = 1;
            m_env = m_env + step;
        end else if (mag < m_env) begin
            diff = m_env - mag;
            step = diff >> r;
            if (step == 0) step = 1;
            m_env = m_env - step;
        end
        amp = m_env >> 7;
        case (m_state)
            0: if (amp >= int'(open_th)) m_state = 1;
            1: if (amp < int'(close_th)) begin
                   m_state = 2;
                   m_cnt   = 1;
                   if (m_cnt >= int'(HOLD)) begin
                       m_state = 0;
                       m_cnt   = 0;
                   end
               end
            default: begin
                if (amp >= int'(close_th)) begin
                    m_state = 1;
                    m_cnt   = 0;
                end else begin
                    m_cnt = m_cnt + 1;
                    if (m_cnt == int'(HOLD)) begin
                        m_state = 0;
                        m_cnt   = 0;
                    end
                end
            end
        endcase
        e.amp  = m_amp();
        e.gate = m_gate();
        q.push_back(e);
    endtask

    // Scoreboard monitor: every out_valid must match the oldest prediction.
    always @(negedge clk) begin
        if (reset_n && out_valid) begin
            if (q.size() == 0) begin
                checks   = checks + 1;
                failures = failures + 1;
                $display("FAIL unexpected_out_valid amplitude=%0d gate=%0b with no sample pending", amplitude, gate);
            end else begin
                exp_t e;
                e = q.pop_front();
                checks = checks + 1;
                if (amplitude !== e.amp) begin
                    failures = failures + 1;
                    $display("FAIL sb_amplitude got=%0d exp=%0d", amplitude, e.amp);
                end
                checks = checks + 1;
                if (gate !== e.gate) begin
                    failures = failures + 1;
                    $display("FAIL sb_gate got=%0b exp=%0b (amplitude=%0d)", gate, e.gate, amplitude);
                end
            end
        end
    end

    // Drive one sample for one cycle (caller returns at posedge+1).
    task automatic drive(input logic [SB-1:0] s);
        sample_valid = 1'b1;
        sample       = s;
        model_push(s);
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
    endtask

    // Wait for all predictions to be consumed, bounded.
    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks = checks + 1;
        if (q.size() != 0) begin
            failures = failures + 1;
            $display("FAIL drain_timeout pending=%0d exp=0", q.size());
            q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n      = 1'b0;
        sample_valid = 1'b0;
        sample       = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks = checks + 3;
        if (amplitude !== 8'd0) begin
            failures++; $display("FAIL reset_amplitude got=%0d exp=0", amplitude);
        end
        if (gate !== 1'b0) begin
            failures++; $display("FAIL reset_gate got=%0b exp=0", gate);
        end
        if (out_valid !== 1'b0) begin
            failures++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset_midstream();
        // Two samples in flight, then reset: neither may emerge.
        sample_valid = 1'b1;
        sample       = 16'sh4000;
        @(posedge clk);
        #1;
        sample       = 16'sh7000;
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
        reset_n      = 1'b0;
        @(negedge clk);
        checks = checks + 3;
        if (amplitude !== 8'd0) begin
            failures++; $display("FAIL mid_reset_amplitude got=%0d exp=0", amplitude);
        end
        if (gate !== 1'b0) begin
            failures++; $display("FAIL mid_reset_gate got=%0b exp=0", gate);
        end
        if (out_valid !== 1'b0) begin
            failures++; $display("FAIL mid_reset_out_valid got=%0b exp=0", out_valid);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
        q.delete();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks = checks + 1;
            if (out_valid !== 1'b0) begin
                failures++; $display("FAIL flushed_out_valid cycle=%0d got=%0b exp=0", i, out_valid);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_instant();
        a = 4'd0;
        r = 4'd0;
        sample_valid = 1'b1;
        sample       = 16'sh4000;
        model_push(16'sh4000);
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
        // Sampled at this edge; out_valid must appear 3 edges later.
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            checks = checks + 1;
            if (out_valid !== (i == 3)) begin
                failures++; $display("FAIL latency edge=%0d got=%0b exp=%0b", i, out_valid, (i == 3));
            end
        end
        drain();
        drive(16'shC000);
        drain();
        checks = checks + 1;
        if (amplitude !== 8'h80) begin
            failures++; $display("FAIL instant_negative got=%0h exp=80", amplitude);
        end
    endtask

    task automatic test_saturation();
        drive(16'sh8000);
        drain();
        checks = checks + 1;
        if (amplitude !== 8'hFF) begin
            failures++; $display("FAIL saturation got=%0h exp=ff", amplitude);
        end
    endtask

    task automatic test_attack();
        a = 4'd0;
        r = 4'd0;
        drive(16'sh0000);
        drain();
        a = 4'd1;
        for (int i = 0; i < 20; i++) begin
            sample_valid = 1'b1;
            sample       = 16'sh7FFF;
            model_push(16'sh7FFF);
            @(posedge clk);
            #1;
        end
        sample_valid = 1'b0;
        drain();
        checks = checks + 1;
        if (amplitude !== 8'hFF) begin
            failures++; $display("FAIL attack_final got=%0h exp=ff", amplitude);
        end
        a = 4'd0;
    endtask

    task automatic test_hysteresis();
        open_th  = 8'd100;
        close_th = 8'd40;
        a = 4'd0;
        r = 4'd0;
        for (int i = 0; i < 5; i++) drive(16'sh0000);
        drain();
        checks = checks + 1;
        if (gate !== 1'b0) begin
            failures++; $display("FAIL hyst_precondition gate got=%0b exp=0", gate);
        end
        drive(16'(120 << 7));
        drain();
        checks = checks + 1;
        if (gate !== 1'b1) begin
            failures++; $display("FAIL hyst_open gate got=%0b exp=1", gate);
        end
        for (int i = 0; i < 3; i++) drive(16'(30 << 7));
        drive(16'(50 << 7));
        drain();
        checks = checks + 1;
        if (gate !== 1'b1) begin
            failures++; $display("FAIL hyst_rearm gate got=%0b exp=1", gate);
        end
        for (int i = 0; i < 3; i++) drive(16'(30 << 7));
        drain();
        checks = checks + 1;
        if (gate !== 1'b1) begin
            failures++; $display("FAIL hyst_third_below gate got=%0b exp=1", gate);
        end
        drive(16'(30 << 7));
        drain();
        checks = checks + 1;
        if (gate !== 1'b0) begin
            failures++; $display("FAIL hyst_expire gate got=%0b exp=0", gate);
        end
    endtask

    task automatic test_back_to_back();
        int cnt;
        int first;
        int last;
        logic [7:0] amp_hold;
        logic       gate_hold;
        cnt   = 0;
        first = -1;
        last  = -1;
        a = 4'd0;
        r = 4'd0;
        for (int i = 0; i < 14; i++) begin
            if (i < 8) begin
                logic [SB-1:0] s;
                s = SB'($urandom_range(0, 65535));
                sample_valid = 1'b1;
                sample       = s;
                model_push(s);
            end else begin
                sample_valid = 1'b0;
            end
            @(negedge clk);
            if (out_valid === 1'b1) begin
                cnt++;
                if (first < 0) first = i;
                last = i;
            end
            @(posedge clk);
            #1;
        end
        sample_valid = 1'b0;
        drain();
        checks = checks + 2;
        if (cnt != 8) begin
            failures++; $display("FAIL b2b_count got=%0d exp=8", cnt);
        end
        if ((last - first) != 7) begin
            failures++; $display("FAIL b2b_contiguous span got=%0d exp=7", last - first);
        end
        amp_hold  = m_amp();
        gate_hold = m_gate();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks = checks + 1;
            if (out_valid !== 1'b0 || amplitude !== amp_hold || gate !== gate_hold) begin
                failures++;
                $display("FAIL idle_hold cycle=%0d got ov=%0b amp=%0d gate=%0b exp ov=0 amp=%0d gate=%0b",
                         i, out_valid, amplitude, gate, amp_hold, gate_hold);
            end
        end
        @(posedge clk);
        #1;
        // The next sample must follow from the held env/FSM state.
        drive(16'(45 << 7));
        drain();
    endtask

    initial begin
        reset_n      = 1'b0;
        sample_valid = 1'b0;
        sample       = '0;
        a            = 4'd0;
        r            = 4'd0;
        open_th      = 8'd200;
        close_th     = 8'd100;
        test_reset();
        test_reset_midstream();
        test_instant();
        test_saturation();
        test_attack();
        test_hysteresis();
        test_back_to_back();
        checks = checks + 1;
        if (q.size() != 0) begin
            failures++; $display("FAIL final_queue pending=%0d exp=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not complete got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/envelope_follower.md
Name: envelope_follower

Overview:
- Inverse of the synth's envelope generator: recovers an 8-bit amplitude envelope and a gate signal from a stream of signed audio samples.
- Sits on the audio-in path at the 48 kHz sample strobe rate.
- Output suits VU metering, noise gating, or retriggering the synth envelope from external audio.
- Attack and release are selected by 4-bit parameters in the same style as the envelope generator.

Parameters:
- SAMPLE_BITS, 16, width of the signed input sample (must be >= 9).
- HOLD_SAMPLES, 2400, number of consecutive valid samples below the close threshold before the gate drops (50 ms at 48 kHz); must be >= 1.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous active-low reset.
- sample_valid  in  1  one-cycle strobe qualifying sample; may be asserted every cycle.
- sample  in  SAMPLE_BITS  signed two's-complement audio sample.
- a  in  4  attack smoothing shift; 0 = instant.
- r  in  4  release smoothing shift; 0 = instant.
- open_th  in  8  amplitude at or above which the gate opens.
- close_th  in  8  amplitude below which the hold count runs. open_th > close_th is the user's responsibility, not checked.
- amplitude  out  8  envelope magnitude.
- gate  out  1  detected note/signal-present gate.
- out_valid  out  1  one-cycle strobe; amplitude and gate were updated this cycle.

Behaviour:
- Reset (reset_n low at posedge clk): clears all pipeline registers and the internal envelope (env). Also sets:
  - amplitude = 0, gate = 0, out_valid = 0
  - state = CLOSED, hold counter = 0
  - Reset mid-stream discards in-flight samples; no out_valid is produced for them.
- Stage 1 (the cycle sample_valid is sampled):
  - mag = |sample|, width SAMPLE_BITS-1, unsigned.
  - The most negative input saturates to 2^(SAMPLE_BITS-1)-1; e.g. -32768 gives 32767.
- Stage 2 (env, unsigned SAMPLE_BITS-1 bits):
  - If mag > env: step = (mag-env) >> a.
  - Else: step = (env-mag) >> r.
  - If the difference is nonzero and step is 0, step = 1 so env always converges exactly.
  - env moves toward mag by step and never overshoots mag.
  - If mag == env, env is unchanged.
  - a and r are sampled combinationally at stage 2.
- Stage 3 (outputs):
  - amplitude = env[SAMPLE_BITS-2 -: 8], the top 8 bits of the magnitude.
  - The gate FSM is evaluated on that new amplitude value.
  - out_valid pulses for one cycle.
- Latency: sample_valid at cycle N gives out_valid at cycle N+3.
  - Fully pipelined: back-to-back valid samples produce back-to-back out_valid.
  - No sample_valid means no state change (env, FSM and counter hold).
- Gate FSM, advanced only on stage-3 updates:
  - CLOSED (gate=0): amplitude >= open_th goes to OPEN, gate=1 in the same update. Otherwise stay.
  - OPEN (gate=1): amplitude < close_th goes to HOLD with hold counter = 1. Otherwise stay.
  - HOLD (gate=1):
    - amplitude >= close_th: back to OPEN, counter cleared.
    - Otherwise the counter increments; when it reaches HOLD_SAMPLES, go to CLOSED with gate=0 and counter cleared.
  - With HOLD_SAMPLES=1, the gate closes on the first below-threshold update (OPEN goes straight to CLOSED).
  - Simultaneous conditions in the same update: the comparison uses the freshly computed amplitude, and re-arming (>= close_th) takes priority over expiry.
- Counter width: clog2(HOLD_SAMPLES+1). No wrap is possible because it clears on reaching HOLD_SAMPLES.
- Parameter changes (a, r, thresholds) take effect on the next processed sample; there are no glitches on the outputs.

Test Plan:
- Reset: assert reset_n=0 mid-stream with 2 samples in flight -> amplitude=0, gate=0, out_valid=0; no out_valid for the flushed samples.
- Instant tracking: a=0, r=0, samples 16'sh4000 then 16'shC000 -> out_valid at N+3; amplitude=8'h80 both times (|-16384|=16384).
- Saturation: a=0, sample 16'sh8000 -> amplitude=8'hFF, and env=32767 (no overflow to 0).
- Attack smoothing: a=1, env=0, repeated samples of 16'sh7FFF -> env = 16383, 24575, 28671, ... reaching 32767 exactly (min-step-1 rule); amplitude never exceeds 8'hFF.
- Gate hysteresis: open_th=100, close_th=40, HOLD_SAMPLES=4, a=r=0:
  - Amplitude 120 -> gate=1 on the first update.
  - Then 30 for 3 samples, then 50 -> gate stays 1 (back in OPEN).
  - Then 30 for 4 samples -> gate=0 exactly on the 4th update.
- Back-to-back and idle: sample_valid high for 8 consecutive cycles -> 8 consecutive out_valid pulses; then 10 idle cycles -> amplitude, gate and FSM state unchanged.
